// File: rtl/cmp_pkg.sv
// Shared constants, FSM state type and length-mask helper for the
// compressed-line packer.
package cmp_pkg;

    localparam int CACHE_LINE = 128;  // compressed-line budget in bits
    localparam int WORD_SIZE  = 64;   // widest codeword in bits
    localparam int LEN_W      = 7;    // codeword length field, holds 0..WORD_SIZE
    localparam int CNT_W      = 8;    // accumulated bit count, holds 0..CACHE_LINE+WORD_SIZE

    typedef enum logic {
        PACK = 1'b0,
        EMIT = 1'b1
    } pack_state_t;

    // Mask with the low `len` bits set; lengths at or above WORD_SIZE give all ones.
    function automatic logic [WORD_SIZE-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [WORD_SIZE-1:0] mask;
        if (len >= LEN_W'(WORD_SIZE)) begin
            mask = '1;
        end else begin
            mask = ~({WORD_SIZE{1'b1}} << len);
        end
        return mask;
    endfunction

endpackage

// File: rtl/compressed_line_packer_bit_inserter.sv
// Combinational codeword insertion: masks a codeword to its length and ORs
// it into the line buffer starting at bit position ptr. Kept separate so it
// can be unit-checked and later split into a pipeline stage.
module bit_inserter
    import cmp_pkg::*;
(
    input  logic [CACHE_LINE-1:0] buffer,
    input  logic [CNT_W-1:0]      ptr,
    input  logic [WORD_SIZE-1:0]  code,
    input  logic [LEN_W-1:0]      len,
    output logic [CACHE_LINE-1:0] new_buffer
);

    logic [CACHE_LINE-1:0] field;

    // Zero-extend the masked codeword to line width, then shift it into place.
    always_comb begin
        field      = {{(CACHE_LINE-WORD_SIZE){1'b0}}, code & len_mask(len)};
        new_buffer = buffer | (field << ptr);
    end

endmodule

// File: rtl/compressed_line_packer.sv
// Compressed-line packer: accumulates variable-length codewords LSB-first
// into a CACHE_LINE-bit buffer and hands the finished line downstream with
// its requested bit count and a flag saying whether it fit the budget.
module compressed_line_packer
    import cmp_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WORD_SIZE-1:0]  i_code,
    input  logic [LEN_W-1:0]      i_len,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CACHE_LINE-1:0] o_line,
    output logic [CNT_W-1:0]      o_bits,
    output logic                  o_compressed,
    output logic                  o_len_err
);

    pack_state_t           state;
    logic [CACHE_LINE-1:0] buffer;
    logic [CNT_W-1:0]      ptr;
    logic                  ovf;

    logic                  accept;
    logic                  len_big;
    logic [LEN_W-1:0]      len_eff;
    logic [CNT_W:0]        sum;
    logic                  fits;
    logic                  ovf_next;
    logic [CNT_W-1:0]      ptr_next;
    logic [CACHE_LINE-1:0] inserted;
    logic [CACHE_LINE-1:0] buffer_next;

    bit_inserter u_bit_inserter (
        .buffer     (buffer),
        .ptr        (ptr),
        .code       (i_code),
        .len        (len_eff),
        .new_buffer (inserted)
    );

    // Per-codeword arithmetic: clamp the length, extend the pointer one bit so
    // the budget check and saturation see the true sum, and decide whether
    // this codeword still lands inside the line.
    always_comb begin
        accept      = i_valid && o_ready;
        len_big     = i_len > LEN_W'(WORD_SIZE);
        len_eff     = len_big ? LEN_W'(WORD_SIZE) : i_len;
        sum         = {1'b0, ptr} + (CNT_W+1)'(len_eff);
        fits        = !ovf && (sum <= (CNT_W+1)'(CACHE_LINE));
        ovf_next    = ovf || (sum > (CNT_W+1)'(CACHE_LINE));
        ptr_next    = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        buffer_next = fits ? inserted : buffer;
    end

    // Packing FSM: accumulate in PACK, present the finished line in EMIT until
    // downstream takes it, then clear the line state for the next one.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= PACK;
            buffer       <= '0;
            ptr          <= '0;
            ovf          <= 1'b0;
            o_ready      <= 1'b1;
            o_valid      <= 1'b0;
            o_line       <= '0;
            o_bits       <= '0;
            o_compressed <= 1'b0;
            o_len_err    <= 1'b0;
        end else begin
            if (accept && len_big) begin
                o_len_err <= 1'b1;
            end
            case (state)
                PACK: begin
                    if (accept) begin
                        if (i_last) begin
                            // The line leaves straight from the next-state values so
                            // the closing codeword is included with one cycle latency.
                            state        <= EMIT;
                            o_ready      <= 1'b0;
                            o_valid      <= 1'b1;
                            o_line       <= buffer_next;
                            o_bits       <= ptr_next;
                            o_compressed <= !ovf_next;
                        end else begin
                            buffer <= buffer_next;
                            ptr    <= ptr_next;
                            ovf    <= ovf_next;
                        end
                    end
                end
                EMIT: begin
                    if (i_ready) begin
                        state        <= PACK;
                        buffer       <= '0;
                        ptr          <= '0;
                        ovf          <= 1'b0;
                        o_ready      <= 1'b1;
                        o_valid      <= 1'b0;
                        o_line       <= '0;
                        o_bits       <= '0;
                        o_compressed <= 1'b0;
                    end
                end
                default: begin
                    state   <= PACK;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compressed_line_packer.sv
// Bench for compressed_line_packer: a bit-level line model fed by the driver,
// one per-cycle compare process, directed boundary lines with literal
// expectations, and a randomized phase with random downstream back-pressure.
module tb_compressed_line_packer;
    import cmp_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  i_valid;
    logic                  o_ready;
    logic [WORD_SIZE-1:0]  i_code;
    logic [LEN_W-1:0]      i_len;
    logic                  i_last;
    logic                  o_valid;
    logic                  i_ready;
    logic [CACHE_LINE-1:0] o_line;
    logic [CNT_W-1:0]      o_bits;
    logic                  o_compressed;
    logic                  o_len_err;

    int checks = 0;
    int errors = 0;

    logic rand_ready  = 1'b0;
    logic fixed_ready = 1'b1;

    typedef struct {
        logic [CACHE_LINE-1:0] line;
        int                    bits;
        logic                  comp;
    } exp_t;

    exp_t                  exp_q[$];
    logic [CACHE_LINE-1:0] m_line = '0;
    int                    m_ptr = 0;
    bit                    m_ovf = 1'b0;
    bit                    m_len_err = 1'b0;

    compressed_line_packer dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_code       (i_code),
        .i_len        (i_len),
        .i_last       (i_last),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_line       (o_line),
        .o_bits       (o_bits),
        .o_compressed (o_compressed),
        .o_len_err    (o_len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CACHE_LINE-1:0] act,
                       input logic [CACHE_LINE-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Line model: walk the codeword bit by bit into a 128-bit image.
    task automatic model_accept(input logic [WORD_SIZE-1:0] code, input int len,
                                input logic last);
        int   l;
        exp_t e;
        l = (len > WORD_SIZE) ? WORD_SIZE : len;
        if (len > WORD_SIZE) m_len_err = 1'b1;
        if (!m_ovf && (m_ptr + l <= CACHE_LINE)) begin
            for (int i = 0; i < l; i++) m_line[m_ptr + i] = code[i];
        end
        if (m_ptr + l > CACHE_LINE) m_ovf = 1'b1;
        m_ptr = (m_ptr + l > 255) ? 255 : m_ptr + l;
        if (last) begin
            e.line = m_line;
            e.bits = m_ptr;
            e.comp = !m_ovf;
            exp_q.push_back(e);
            m_line = '0;
            m_ptr  = 0;
            m_ovf  = 1'b0;
        end
    endtask

    // Literal expectation on the most recently completed model line.
    task automatic pin(input string name, input logic [CACHE_LINE-1:0] line,
                       input int bits, input logic comp);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: model has no line, required bits %0d", name, bits);
        end else begin
            chk({name, "_line"}, exp_q[exp_q.size()-1].line, line);
            chk({name, "_bits"}, CACHE_LINE'(exp_q[exp_q.size()-1].bits), CACHE_LINE'(bits));
            chk({name, "_comp"}, CACHE_LINE'(exp_q[exp_q.size()-1].comp), CACHE_LINE'(comp));
        end
    endtask

    // Present one codeword from posedge+1 and hold it until it is taken.
    task automatic send(input logic [WORD_SIZE-1:0] code, input int len, input logic last);
        int waited;
        waited  = 0;
        i_valid = 1'b1;
        i_code  = code;
        i_len   = LEN_W'(len);
        i_last  = last;
        @(negedge clk);
        while (!o_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: o_ready %b after %0d cycles, required 1", o_ready, waited);
            i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(code, len, last);
        #1;
        i_valid = 1'b0;
        i_code  = {$urandom, $urandom};
        i_len   = LEN_W'($urandom_range(0, 127));
        i_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending lines %0d, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, CACHE_LINE'(o_ready), CACHE_LINE'(1));
        chk({name, "_valid"}, CACHE_LINE'(o_valid), CACHE_LINE'(0));
        chk({name, "_line"}, o_line, '0);
        chk({name, "_bits"}, CACHE_LINE'(o_bits), CACHE_LINE'(0));
        chk({name, "_comp"}, CACHE_LINE'(o_compressed), CACHE_LINE'(0));
        chk({name, "_lenerr"}, CACHE_LINE'(o_len_err), CACHE_LINE'(0));
    endtask

    // Downstream ready: random back-pressure or a fixed level, updated after each edge.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_ready = rand_ready ? ($urandom_range(0, 2) != 0) : fixed_ready;
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("o_valid", CACHE_LINE'(o_valid), CACHE_LINE'(exp_q.size() != 0));
                chk("o_ready", CACHE_LINE'(o_ready), CACHE_LINE'(exp_q.size() == 0));
                chk("o_len_err", CACHE_LINE'(o_len_err), CACHE_LINE'(m_len_err));
                if (o_valid && exp_q.size() != 0) begin
                    chk("o_line", o_line, exp_q[0].line);
                    chk("o_bits", CACHE_LINE'(o_bits), CACHE_LINE'(exp_q[0].bits));
                    chk("o_compressed", CACHE_LINE'(o_compressed), CACHE_LINE'(exp_q[0].comp));
                    if (i_ready) begin
                        @(posedge clk);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [WORD_SIZE-1:0] c1;
        logic [WORD_SIZE-1:0] c2;
        logic [WORD_SIZE-1:0] c3;
        int                   n;
        int                   len;

        i_valid = 1'b0;
        i_code  = '0;
        i_len   = '0;
        i_last  = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two full-width codewords: exactly 128 bits
        send(64'hAAAA_AAAA_AAAA_AAAA, 64, 1'b0);
        send(64'h5555_5555_5555_5555, 64, 1'b1);
        pin("full128", {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA}, 128, 1'b1);
        @(negedge clk);
        chk("full128_latency", CACHE_LINE'(o_valid), CACHE_LINE'(1));
        wait_idle();

        // Short codewords with garbage above len, including a zero-length one
        send(64'hDEAD_BEEF_0000_0005, 3, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 5, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFF6, 4, 1'b1);
        pin("mask12", 128'h6FD, 12, 1'b1);
        wait_idle();

        // 129 bits: overflow on the closing codeword
        c1 = {$urandom, $urandom};
        c2 = {$urandom, $urandom};
        c3 = {$urandom, $urandom};
        send(c1, 64, 1'b0);
        send(c2, 60, 1'b0);
        send(c3, 5, 1'b1);
        pin("ovf129", {4'h0, c2[59:0], c1}, 129, 1'b0);
        wait_idle();

        // Downstream stalls for several cycles while upstream keeps offering a codeword
        fixed_ready = 1'b0;
        @(posedge clk);
        #1;
        send(64'hFFFF_FFFF_FFFF_FFA5, 8, 1'b1);
        pin("hold_first", 128'hA5, 8, 1'b1);
        fork
            send(64'hFFFF_FFFF_FFFF_1234, 16, 1'b1);
            begin
                repeat (6) @(posedge clk);
                fixed_ready = 1'b1;
            end
        join
        pin("hold_next", 128'h1234, 16, 1'b1);
        wait_idle();

        // Over-long length clamps to 64 and raises the sticky error
        send(64'hFFFF_FFFF_FFFF_FFFF, 80, 1'b1);
        pin("len80", {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 64, 1'b1);
        @(negedge clk);
        chk("len80_err", CACHE_LINE'(o_len_err), CACHE_LINE'(1));
        wait_idle();

        // Random lines with random downstream back-pressure
        rand_ready = 1'b1;
        for (int line_i = 0; line_i < 60; line_i++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) len = $urandom_range(65, 127);
                else len = $urandom_range(0, 64);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                send({$urandom, $urandom}, len, (k == n - 1));
            end
        end
        rand_ready  = 1'b0;
        fixed_ready = 1'b1;
        wait_idle();

        // Asynchronous reset mid-line discards the partial line
        send(64'h0000_0000_0000_BEEF, 16, 1'b0);
        send(64'h0000_0000_0000_CAFE, 16, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        m_line    = '0;
        m_ptr     = 0;
        m_ovf     = 1'b0;
        m_len_err = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFC3, 8, 1'b1);
        pin("after_reset", 128'hC3, 8, 1'b1);
        @(negedge clk);
        chk("after_reset_line", o_line, 128'hC3);
        chk("after_reset_bits", CACHE_LINE'(o_bits), CACHE_LINE'(8));
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
